// File: rtl/rst_ctrl_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM encoding,
// default timing values and the names of the core reset domains.
package rst_ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam int unsigned DEF_ASSERT_CYC  = 32'd16;
    localparam int unsigned DEF_GAP_CYC     = 32'd4;
    localparam int unsigned DEF_TIMEOUT_CYC = 32'd1024;

    // Release order of the core domains
    localparam logic [2:0] DOM_MAC        = 3'd0;
    localparam logic [2:0] DOM_TL         = 3'd1;
    localparam logic [2:0] DOM_MEM_BRIDGE = 3'd2;
    localparam logic [2:0] DOM_PERIPH     = 3'd3;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/rst_ctrl_seq_sync_bit_n.sv
// Multi-stage single-bit synchronizer for bringing an asynchronous level
// into the clk domain.
module sync_bit_n #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_r;

    // Shift the input through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_r <= '0;
        end else begin
            ff_r <= {ff_r[STAGES-2:0], d};
        end
    end

    assign q = ff_r[STAGES-1];

endmodule

// File: rtl/rst_ctrl_seq.sv
// Reset sequencer: holds all core domains in reset after a start request,
// then releases them one by one, waiting for each domain's ready handshake.
module rst_ctrl_seq
    import rst_ctrl_seq_pkg::*;
#(
    parameter int unsigned NUM_DOM     = 4,
    parameter int unsigned ASSERT_CYC  = DEF_ASSERT_CYC,
    parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwr2rst_rst_ctrl_start,
    input  logic               sw_rst_req,
    input  logic [NUM_DOM-1:0] dom_rdy,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               rst_busy,
    output logic               rst_done,
    output logic               rst_err,
    output logic [2:0]         err_dom
);

    localparam int unsigned CNT_W = $clog2(max3(ASSERT_CYC, GAP_CYC, TIMEOUT_CYC) + 1);

    // HOLD terminates on ASSERT_CYC (not ASSERT_CYC-1): the start-acknowledge
    // cycle is followed by ASSERT_CYC full cycles of held reset.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ASSERT_CYC);
    localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYC == 0) ? '0 : CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(NUM_DOM - 1);
    localparam logic [NUM_DOM-1:0] ONE     = NUM_DOM'(1);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2:0]         idx_r;
    logic [NUM_DOM-1:0] rdy_s;
    logic               start_s;
    logic               rdy_cur_s;
    logic [NUM_DOM-1:0] rel_bit_s;

    for (genvar g = 0; g < NUM_DOM; g++) begin : g_sync
        sync_bit_n #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (dom_rdy[g]),
            .q   (rdy_s[g])
        );
    end

    // Start request and per-index views of the synchronized ready vector
    always_comb begin
        start_s   = 1'b0;
        rdy_cur_s = 1'b0;
        rel_bit_s = '0;
        start_s   = pwr2rst_rst_ctrl_start | sw_rst_req;
        rdy_cur_s = |(rdy_s & (ONE << idx_r));
        rel_bit_s = ONE << (idx_r + 3'd1);
    end

    // Sequencer FSM with registered outputs; a start request overrides every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            idx_r     <= 3'd0;
            dom_rst_n <= '0;
            rst_busy  <= 1'b0;
            rst_done  <= 1'b0;
            rst_err   <= 1'b0;
            err_dom   <= 3'd0;
        end else if (start_s) begin
            state_r   <= ST_HOLD;
            cnt_r     <= '0;
            idx_r     <= 3'd0;
            dom_rst_n <= '0;
            rst_busy  <= 1'b1;
            rst_done  <= 1'b0;
            rst_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    dom_rst_n <= '0;
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_r   <= ST_WAIT;
                        cnt_r     <= '0;
                        dom_rst_n <= ONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (rdy_cur_s) begin
                        cnt_r <= '0;
                        if (idx_r == LAST_IDX) begin
                            state_r  <= ST_DONE;
                            rst_done <= 1'b1;
                            rst_busy <= 1'b0;
                        end else if (GAP_CYC == 0) begin
                            idx_r     <= idx_r + 3'd1;
                            dom_rst_n <= dom_rst_n | rel_bit_s;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end else if ((TIMEOUT_CYC != 0) && (cnt_r == TO_LAST)) begin
                        state_r   <= ST_ERR;
                        cnt_r     <= '0;
                        dom_rst_n <= '0;
                        rst_err   <= 1'b1;
                        err_dom   <= idx_r;
                        rst_busy  <= 1'b0;
                    end else if (TIMEOUT_CYC != 0) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        // Timeout disabled: counter parks so WAIT can last forever
                        cnt_r <= cnt_r;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r   <= ST_WAIT;
                        cnt_r     <= '0;
                        idx_r     <= idx_r + 3'd1;
                        dom_rst_n <= dom_rst_n | rel_bit_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                ST_ERR: begin
                    dom_rst_n <= '0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= '0;
                    idx_r     <= 3'd0;
                    dom_rst_n <= '0;
                    rst_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_ctrl_seq.sv
// Directed self-checking bench for rst_ctrl_seq: a main instance plus
// GAP_CYC=0 and TIMEOUT_CYC=0 variants sharing clock, reset and start.
module tb_rst_ctrl_seq;
    import rst_ctrl_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sw_req = 1'b0;
    logic [3:0] rdy_m = 4'b0000;
    logic [3:0] rdy_g = 4'b0000;
    logic [3:0] rdy_t = 4'b0000;

    logic [3:0] rn_m, rn_g, rn_t;
    logic       busy_m, done_m, err_m;
    logic       busy_g, done_g, err_g;
    logic       busy_t, done_t, err_t;
    logic [2:0] ed_m, ed_g, ed_t;

    int tests = 0;
    int fails = 0;

    rst_ctrl_seq #(.NUM_DOM(4), .ASSERT_CYC(16), .GAP_CYC(4), .TIMEOUT_CYC(64), .SYNC_STAGES(2)) u_main (
        .clk(clk), .rst(rst), .pwr2rst_rst_ctrl_start(start), .sw_rst_req(sw_req),
        .dom_rdy(rdy_m), .dom_rst_n(rn_m), .rst_busy(busy_m), .rst_done(done_m),
        .rst_err(err_m), .err_dom(ed_m));

    rst_ctrl_seq #(.NUM_DOM(4), .ASSERT_CYC(16), .GAP_CYC(0), .TIMEOUT_CYC(64), .SYNC_STAGES(2)) u_gap0 (
        .clk(clk), .rst(rst), .pwr2rst_rst_ctrl_start(start), .sw_rst_req(sw_req),
        .dom_rdy(rdy_g), .dom_rst_n(rn_g), .rst_busy(busy_g), .rst_done(done_g),
        .rst_err(err_g), .err_dom(ed_g));

    rst_ctrl_seq #(.NUM_DOM(4), .ASSERT_CYC(16), .GAP_CYC(4), .TIMEOUT_CYC(0), .SYNC_STAGES(2)) u_to0 (
        .clk(clk), .rst(rst), .pwr2rst_rst_ctrl_start(start), .sw_rst_req(sw_req),
        .dom_rdy(rdy_t), .dom_rst_n(rn_t), .rst_busy(busy_t), .rst_done(done_t),
        .rst_err(err_t), .err_dom(ed_t));

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({rn_m, busy_m, done_m, err_m, ed_m} !== 10'd0) begin
            fails++; $display("FAIL reset_main: got %b expected 0", {rn_m, busy_m, done_m, err_m, ed_m});
        end
        tests++;
        if ({rn_g, busy_g, done_g, err_g, ed_g, rn_t, busy_t, done_t, err_t, ed_t} !== 20'd0) begin
            fails++; $display("FAIL reset_variants: got %b expected 0",
                              {rn_g, busy_g, done_g, err_g, ed_g, rn_t, busy_t, done_t, err_t, ed_t});
        end
        tick(3);
        rst = 1'b0;
        tick(5);
        tests++;
        if ({rn_m, busy_m} !== 5'd0) begin
            fails++; $display("FAIL idle_after_reset: got %b expected 0", {rn_m, busy_m});
        end
    endtask

    // Main instance, called right after the start edge; first n_ok domains answer 3 cycles after release
    task automatic chain(input int n_ok);
        logic [3:0] exp_mask;
        tests++;
        if (rn_m !== 4'b0000 || busy_m !== 1'b1 || done_m !== 1'b0 || err_m !== 1'b0) begin
            fails++; $display("FAIL start_ack: got rn=%b busy=%b done=%b err=%b expected 0000 1 0 0",
                              rn_m, busy_m, done_m, err_m);
        end
        tick(16);
        tests++;
        if (rn_m !== 4'b0000) begin
            fails++; $display("FAIL hold_end: got %b expected 0000", rn_m);
        end
        tick(1);
        tests++;
        if (rn_m !== 4'b0001) begin
            fails++; $display("FAIL release_dom0: got %b expected 0001", rn_m);
        end
        for (int i = 0; i < n_ok; i++) begin
            tick(3);
            rdy_m[i] = 1'b1;
            if (i < 3) begin
                exp_mask = 4'((1 << (i + 1)) - 1);
                tick(6);
                tests++;
                if (rn_m !== exp_mask) begin
                    fails++; $display("FAIL pre_release_%0d: got %b expected %b", i + 1, rn_m, exp_mask);
                end
                exp_mask = 4'((1 << (i + 2)) - 1);
                tick(1);
                tests++;
                if (rn_m !== exp_mask) begin
                    fails++; $display("FAIL release_%0d: got %b expected %b", i + 1, rn_m, exp_mask);
                end
            end else begin
                tick(2);
                tests++;
                if (done_m !== 1'b0 || busy_m !== 1'b1) begin
                    fails++; $display("FAIL pre_done: got done=%b busy=%b expected 0 1", done_m, busy_m);
                end
                tick(1);
                tests++;
                if (done_m !== 1'b1 || busy_m !== 1'b0 || err_m !== 1'b0 || rn_m !== 4'b1111) begin
                    fails++; $display("FAIL done: got done=%b busy=%b err=%b rn=%b expected 1 0 0 1111",
                                      done_m, busy_m, err_m, rn_m);
                end
            end
        end
    endtask

    task automatic test_full_sequence();
        rdy_m = 4'b0000;
        do_start();
        chain(4);
        rdy_m[0] = 1'b0;
        tick(5);
        tests++;
        if (done_m !== 1'b1 || rn_m !== 4'b1111) begin
            fails++; $display("FAIL done_hold: got done=%b rn=%b expected 1 1111", done_m, rn_m);
        end
    endtask

    task automatic test_timeout();
        rdy_m = 4'b0000;
        do_start();
        chain(2);
        tick(63);
        tests++;
        if (err_m !== 1'b0 || rn_m !== 4'b0111 || busy_m !== 1'b1) begin
            fails++; $display("FAIL pre_timeout: got err=%b rn=%b busy=%b expected 0 0111 1", err_m, rn_m, busy_m);
        end
        tick(1);
        tests++;
        if (err_m !== 1'b1 || ed_m !== DOM_MEM_BRIDGE || rn_m !== 4'b0000 || busy_m !== 1'b0) begin
            fails++; $display("FAIL timeout: got err=%b dom=%0d rn=%b busy=%b expected 1 2 0000 0",
                              err_m, ed_m, rn_m, busy_m);
        end
        tick(20);
        tests++;
        if (err_m !== 1'b1 || rn_m !== 4'b0000 || busy_m !== 1'b0) begin
            fails++; $display("FAIL err_sticky: got err=%b rn=%b busy=%b expected 1 0000 0", err_m, rn_m, busy_m);
        end
    endtask

    task automatic test_sw_restart();
        rdy_m = 4'b0000;
        do_start();
        chain(1);
        tick(2);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        rdy_m = 4'b0000;
        tests++;
        if (rn_m !== 4'b0000 || busy_m !== 1'b1 || err_m !== 1'b0 || ed_m !== 3'd2) begin
            fails++; $display("FAIL sw_restart: got rn=%b busy=%b err=%b dom=%0d expected 0000 1 0 2",
                              rn_m, busy_m, err_m, ed_m);
        end
        chain(4);
    endtask

    task automatic test_rdy_preasserted();
        logic [3:0] exp_mask;
        rdy_m = 4'b1111;
        tick(3);
        do_start();
        tick(17);
        tests++;
        if (rn_m !== 4'b0001) begin
            fails++; $display("FAIL pre_rdy_dom0: got %b expected 0001", rn_m);
        end
        for (int i = 1; i < 4; i++) begin
            exp_mask = 4'((1 << i) - 1);
            tick(4);
            tests++;
            if (rn_m !== exp_mask) begin
                fails++; $display("FAIL pre_rdy_hold_%0d: got %b expected %b", i, rn_m, exp_mask);
            end
            exp_mask = 4'((1 << (i + 1)) - 1);
            tick(1);
            tests++;
            if (rn_m !== exp_mask) begin
                fails++; $display("FAIL pre_rdy_rel_%0d: got %b expected %b", i, rn_m, exp_mask);
            end
        end
        tick(1);
        tests++;
        if (done_m !== 1'b1 || busy_m !== 1'b0) begin
            fails++; $display("FAIL pre_rdy_done: got done=%b busy=%b expected 1 0", done_m, busy_m);
        end
    endtask

    task automatic test_async_reset();
        rdy_m = 4'b1111;
        do_start();
        tick(19);
        tests++;
        if (rn_m !== 4'b0001 || busy_m !== 1'b1) begin
            fails++; $display("FAIL mid_gap: got rn=%b busy=%b expected 0001 1", rn_m, busy_m);
        end
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({rn_m, busy_m, done_m, err_m, ed_m} !== 10'd0) begin
            fails++; $display("FAIL async_reset: got %b expected 0", {rn_m, busy_m, done_m, err_m, ed_m});
        end
        tick(2);
        rst = 1'b0;
        tick(30);
        tests++;
        if (rn_m !== 4'b0000 || busy_m !== 1'b0 || done_m !== 1'b0) begin
            fails++; $display("FAIL quiet_after_reset: got rn=%b busy=%b done=%b expected 0000 0 0",
                              rn_m, busy_m, done_m);
        end
    endtask

    task automatic test_start_vs_timeout();
        rdy_m = 4'b0000;
        do_start();
        tick(17);
        tests++;
        if (rn_m !== 4'b0001) begin
            fails++; $display("FAIL svt_dom0: got %b expected 0001", rn_m);
        end
        tick(63);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tests++;
        if (rn_m !== 4'b0000 || busy_m !== 1'b1 || err_m !== 1'b0) begin
            fails++; $display("FAIL start_wins: got rn=%b busy=%b err=%b expected 0000 1 0", rn_m, busy_m, err_m);
        end
        tick(17);
        tests++;
        if (rn_m !== 4'b0001 || err_m !== 1'b0) begin
            fails++; $display("FAIL start_wins_rel: got rn=%b err=%b expected 0001 0", rn_m, err_m);
        end
    endtask

    task automatic test_gap_zero();
        logic [3:0] exp_mask;
        rdy_g = 4'b0000;
        do_start();
        tick(17);
        tests++;
        if (rn_g !== 4'b0001) begin
            fails++; $display("FAIL gap0_dom0: got %b expected 0001", rn_g);
        end
        for (int i = 0; i < 3; i++) begin
            rdy_g[i] = 1'b1;
            exp_mask = 4'((1 << (i + 1)) - 1);
            tick(2);
            tests++;
            if (rn_g !== exp_mask) begin
                fails++; $display("FAIL gap0_hold_%0d: got %b expected %b", i + 1, rn_g, exp_mask);
            end
            exp_mask = 4'((1 << (i + 2)) - 1);
            tick(1);
            tests++;
            if (rn_g !== exp_mask) begin
                fails++; $display("FAIL gap0_rel_%0d: got %b expected %b", i + 1, rn_g, exp_mask);
            end
        end
        rdy_g[DOM_PERIPH] = 1'b1;
        tick(2);
        tests++;
        if (done_g !== 1'b0) begin
            fails++; $display("FAIL gap0_pre_done: got %b expected 0", done_g);
        end
        tick(1);
        tests++;
        if (done_g !== 1'b1 || busy_g !== 1'b0 || err_g !== 1'b0) begin
            fails++; $display("FAIL gap0_done: got done=%b busy=%b err=%b expected 1 0 0", done_g, busy_g, err_g);
        end
    endtask

    task automatic test_timeout_disabled();
        rdy_t = 4'b0000;
        do_start();
        tick(17);
        tests++;
        if (rn_t !== 4'b0001) begin
            fails++; $display("FAIL to0_dom0: got %b expected 0001", rn_t);
        end
        tick(200);
        tests++;
        if (rn_t !== 4'b0001 || err_t !== 1'b0 || busy_t !== 1'b1) begin
            fails++; $display("FAIL to0_wait: got rn=%b err=%b busy=%b expected 0001 0 1", rn_t, err_t, busy_t);
        end
        rdy_t[0] = 1'b1;
        tick(6);
        tests++;
        if (rn_t !== 4'b0001) begin
            fails++; $display("FAIL to0_gap: got %b expected 0001", rn_t);
        end
        tick(1);
        tests++;
        if (rn_t !== 4'b0011 || ed_t !== 3'd0) begin
            fails++; $display("FAIL to0_rel1: got rn=%b dom=%0d expected 0011 0", rn_t, ed_t);
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_timeout();
        test_sw_restart();
        test_rdy_preasserted();
        test_async_reset();
        test_start_vs_timeout();
        test_gap_zero();
        test_timeout_disabled();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
